// File: rtl/cb_pkg.sv
//------------------------------------------------------------------------------
// Module   : cb_pkg
// Purpose  : Shared types and helpers for the configurable connection block:
//            configuration-chain FSM states, config-bit count and the
//            tap-to-track mapping used by the pin multiplexers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cb_pkg;

  // Configuration chain states
  typedef enum logic [1:0] {
    CB_IDLE   = 2'd0,
    CB_SHIFT  = 2'd1,
    CB_LOADED = 2'd2
  } cb_state_e;

  // Total number of configuration bits held by one block
  function automatic int cb_cfg_bits(input int num_pins, input int taps_per_pin);
    return num_pins * taps_per_pin;
  endfunction

  // Track reached by tap t of pin p: pins are staggered by two tracks and
  // taps come in adjacent pairs spaced four tracks apart, wrapping round
  function automatic int cb_tap_track(input int p, input int t, input int channel_width);
    return (2 * p + (t % 2) + 4 * (t / 2)) % channel_width;
  endfunction

endpackage : cb_pkg

`default_nettype wire

// File: rtl/cb_cfg_chain.sv
//------------------------------------------------------------------------------
// Module   : cb_cfg_chain
// Purpose  : Serial configuration chain of the connection block: shadow shift
//            register, saturating bit counter, load FSM and commit status
//            flags. Build option CB_ONEHOT_CHECK_EN rejects commits whose pin
//            fields are not zero or one-hot.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cb_cfg_chain
  import cb_pkg::*;
#(
  parameter int NUM_PINS     = 3,
  parameter int TAPS_PER_PIN = 4,
  parameter int CFG_BITS     = NUM_PINS * TAPS_PER_PIN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_en_i,
  input  logic                cfg_in_i,
  input  logic                cfg_commit_i,
  output logic [CFG_BITS-1:0] shadow_o,
  output logic                load_o,
  output logic                cfg_out_o,
  output logic                cfg_done_o,
  output logic                cfg_valid_o,
  output logic                cfg_err_o
);

  localparam int                CNT_W    = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CFG_BITS);

  cb_state_e           state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                w_fields_ok;
  logic [CNT_W-1:0]    w_count_inc;

`ifdef CB_ONEHOT_CHECK_EN
  logic [NUM_PINS-1:0] w_field_ok;
  for (genvar p = 0; p < NUM_PINS; p++) begin : g_field
    assign w_field_ok[p] = $onehot0(shadow_q[p*TAPS_PER_PIN +: TAPS_PER_PIN]);
  end
  assign w_fields_ok = &w_field_ok;
`else
  assign w_fields_ok = 1'b1;
`endif

  assign w_count_inc = count_q + CNT_W'(1);

  // Next-state logic: a commit in LOADED wins over a simultaneous shift
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    valid_d  = valid_q;
    err_d    = err_q;
    done_d   = 1'b0;
    load_o   = 1'b0;
    if (cfg_commit_i && (state_q == CB_LOADED)) begin
      state_d = CB_IDLE;
      count_d = '0;
      if (w_fields_ok) begin
        load_o  = 1'b1;
        done_d  = 1'b1;
        valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      // Premature commit flags an error but leaves the load in progress alone
      if (cfg_commit_i) begin
        err_d = 1'b1;
      end
      if (cfg_en_i) begin
        shadow_d = {cfg_in_i, shadow_q[CFG_BITS-1:1]};
        case (state_q)
          CB_IDLE: begin
            count_d = CNT_W'(1);
            state_d = CB_SHIFT;
          end
          CB_SHIFT: begin
            count_d = w_count_inc;
            if (w_count_inc == CNT_FULL) begin
              state_d = CB_LOADED;
            end
          end
          default: begin
            count_d = CNT_FULL;
          end
        endcase
      end
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CB_IDLE;
      count_q  <= '0;
      shadow_q <= '0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign shadow_o    = shadow_q;
  assign cfg_out_o   = shadow_q[0];
  assign cfg_done_o  = done_q;
  assign cfg_valid_o = valid_q;
  assign cfg_err_o   = err_q;

endmodule : cb_cfg_chain

`default_nettype wire

// File: rtl/config_connection_block.sv
//------------------------------------------------------------------------------
// Module   : config_connection_block
// Purpose  : FPGA-style connection block. Routing tracks pass straight
//            through; each CLB input pin selects one of its candidate tracks
//            according to a serially loaded, commit-activated configuration.
//            Build option CB_ONEHOT_CHECK_EN enables commit-time field checks.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module config_connection_block
  import cb_pkg::*;
#(
  parameter int CHANNEL_WIDTH = 8,
  parameter int NUM_PINS      = 3,
  parameter int TAPS_PER_PIN  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CHANNEL_WIDTH-1:0] chan_in,
  output logic [CHANNEL_WIDTH-1:0] chan_out,
  output logic [NUM_PINS-1:0]      pin_out,
  input  logic                     cfg_en,
  input  logic                     cfg_in,
  output logic                     cfg_out,
  input  logic                     cfg_commit,
  output logic                     cfg_done,
  output logic                     cfg_valid,
  output logic                     cfg_err
);

  localparam int CFG_BITS = cb_cfg_bits(NUM_PINS, TAPS_PER_PIN);

  logic [CFG_BITS-1:0] w_shadow;
  logic [CFG_BITS-1:0] active_q;
  logic                w_load;

  cb_cfg_chain #(
    .NUM_PINS     (NUM_PINS),
    .TAPS_PER_PIN (TAPS_PER_PIN),
    .CFG_BITS     (CFG_BITS)
  ) u_chain (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_en_i     (cfg_en),
    .cfg_in_i     (cfg_in),
    .cfg_commit_i (cfg_commit),
    .shadow_o     (w_shadow),
    .load_o       (w_load),
    .cfg_out_o    (cfg_out),
    .cfg_done_o   (cfg_done),
    .cfg_valid_o  (cfg_valid),
    .cfg_err_o    (cfg_err)
  );

  // Active configuration captures the shadow only on an accepted commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= '0;
    end else if (w_load) begin
      active_q <= w_shadow;
    end
  end

  assign chan_out = chan_in;

  for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
    logic [TAPS_PER_PIN-1:0] w_hit;
    logic [TAPS_PER_PIN-1:0] w_trk;
    logic [TAPS_PER_PIN-1:0] w_first;

    for (genvar t = 0; t < TAPS_PER_PIN; t++) begin : g_tap
      localparam int TRK = cb_tap_track(p, t, CHANNEL_WIDTH);
      assign w_hit[t] = active_q[p*TAPS_PER_PIN + t];
      assign w_trk[t] = chan_in[TRK];
    end

    // Isolate the lowest set tap so multi-hot fields resolve deterministically
    assign w_first    = w_hit & (~w_hit + TAPS_PER_PIN'(1));
    assign pin_out[p] = cfg_valid & (|(w_first & w_trk));
  end

endmodule : config_connection_block

`default_nettype wire

// File: tb/tb_config_connection_block.sv
//------------------------------------------------------------------------------
// Module   : tb_config_connection_block
// Purpose  : Bench for config_connection_block: two daisy-chained blocks
//            driven by directed and random sequences, compared every cycle
//            against a bit-vector model of the shift/commit rules.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_config_connection_block;

  localparam int CW  = 8;
  localparam int NP  = 3;
  localparam int TP  = 4;
  localparam int CFG = NP * TP;

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] chan_in;
  logic          cfg_en;
  logic          cfg_in;
  logic          cfg_commit;
  logic          w_link;

  logic [CW-1:0] co   [2];
  logic [NP-1:0] po   [2];
  logic          cout [2];
  logic          done [2];
  logic          valid[2];
  logic          err  [2];

  config_connection_block #(.CHANNEL_WIDTH(CW), .NUM_PINS(NP), .TAPS_PER_PIN(TP)) dut0 (
    .clk(clk), .rst_n(rst_n), .chan_in(chan_in), .chan_out(co[0]), .pin_out(po[0]),
    .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_out(cout[0]), .cfg_commit(cfg_commit),
    .cfg_done(done[0]), .cfg_valid(valid[0]), .cfg_err(err[0])
  );

  config_connection_block #(.CHANNEL_WIDTH(CW), .NUM_PINS(NP), .TAPS_PER_PIN(TP)) dut1 (
    .clk(clk), .rst_n(rst_n), .chan_in(chan_in), .chan_out(co[1]), .pin_out(po[1]),
    .cfg_en(cfg_en), .cfg_in(w_link), .cfg_out(cout[1]), .cfg_commit(cfg_commit),
    .cfg_done(done[1]), .cfg_valid(valid[1]), .cfg_err(err[1])
  );

  assign w_link = cout[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per-block shadow/active vectors and flags, shared
  // shift count (both blocks see the same enables and commits)
  logic [CFG-1:0] m_sh   [2];
  logic [CFG-1:0] m_act  [2];
  logic           m_valid[2];
  logic           m_err  [2];
  logic           m_done [2];
  int             m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic fields_ok(input logic [CFG-1:0] v);
`ifdef CB_ONEHOT_CHECK_EN
    for (int p = 0; p < NP; p++) begin
      if ($countones(v[p*TP +: TP]) > 1) return 1'b0;
    end
`endif
    return 1'b1;
  endfunction

  function automatic logic [NP-1:0] exp_pins(input logic [CFG-1:0] act, input logic v,
                                             input logic [CW-1:0] ch);
    logic [NP-1:0] r;
    r = '0;
    if (v) begin
      for (int p = 0; p < NP; p++) begin
        for (int t = 0; t < TP; t++) begin
          if (act[p*TP + t]) begin
            r[p] = ch[(2*p + t%2 + 4*(t/2)) % CW];
            break;
          end
        end
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_sh[b] = '0; m_act[b] = '0; m_valid[b] = 1'b0; m_err[b] = 1'b0; m_done[b] = 1'b0;
    end
    m_cnt = 0;
  endtask

  task automatic model_step(input logic en, input logic din, input logic cm);
    logic o;
    if (cm && (m_cnt == CFG)) begin
      for (int b = 0; b < 2; b++) begin
        if (fields_ok(m_sh[b])) begin
          m_act[b] = m_sh[b]; m_valid[b] = 1'b1; m_done[b] = 1'b1;
        end else begin
          m_err[b] = 1'b1; m_done[b] = 1'b0;
        end
      end
      m_cnt = 0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        m_done[b] = 1'b0;
        if (cm) m_err[b] = 1'b1;
      end
      if (en) begin
        o = m_sh[0][0];
        m_sh[0] = {din, m_sh[0][CFG-1:1]};
        m_sh[1] = {o,   m_sh[1][CFG-1:1]};
        if (m_cnt < CFG) m_cnt++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int b = 0; b < 2; b++) begin
      chk($sformatf("%s_b%0d_chan_out", tag, b), 32'(co[b]),    32'(chan_in));
      chk($sformatf("%s_b%0d_pin_out", tag, b),  32'(po[b]),    32'(exp_pins(m_act[b], m_valid[b], chan_in)));
      chk($sformatf("%s_b%0d_cfg_out", tag, b),  32'(cout[b]),  32'(m_sh[b][0]));
      chk($sformatf("%s_b%0d_done", tag, b),     32'(done[b]),  32'(m_done[b]));
      chk($sformatf("%s_b%0d_valid", tag, b),    32'(valid[b]), 32'(m_valid[b]));
      chk($sformatf("%s_b%0d_err", tag, b),      32'(err[b]),   32'(m_err[b]));
    end
  endtask

  // One clock: drive at negedge, update model at posedge, check at negedge
  task automatic cycle(input string tag, input logic en, input logic din, input logic cm,
                       input logic [CW-1:0] ch);
    cfg_en = en; cfg_in = din; cfg_commit = cm; chan_in = ch;
    @(posedge clk);
    model_step(en, din, cm);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic shift_word(input string tag, input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b1, v[i], 1'b0, 8'($urandom));
  endtask

  task automatic commit(input string tag);
    cycle(tag, 1'b0, 1'b0, 1'b1, 8'($urandom));
  endtask

  task automatic set_chan(input string tag, input logic [CW-1:0] ch);
    chan_in = ch;
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
    cfg_en = 1'b0; cfg_in = 1'b0; cfg_commit = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; chan_in = 8'hA5; cfg_en = 1'b0; cfg_in = 1'b0; cfg_commit = 1'b0;
    model_reset();
    #1;
    check_all("por");
    chk("por_pin_out", 32'(po[0]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single tap on pin0 -> track 0
    shift_word("s001", 32'h001, CFG);
    commit("c001");
    chk("r034_done", 32'(done[0]), 32'h1);
    chk("r034_valid", 32'(valid[0]), 32'h1);
    set_chan("p001", 8'h01);
    chk("r034_pin", 32'(po[0]), 32'h1);
    cycle("idle", 1'b0, 1'b0, 1'b0, 8'h01);
    chk("r034_done_pulse", 32'(done[0]), 32'h0);

    // Pin2 tap1 -> track 5
    shift_word("s200", 32'h200, CFG);
    commit("c200");
    set_chan("p200a", 8'h20);
    chk("r035_hit", 32'(po[0]), 32'h4);
    set_chan("p200b", 8'h10);
    chk("r035_miss", 32'(po[0]), 32'h0);

    // Premature commit, then paused shifting completes the load
    do_reset();
    shift_word("s6", 32'hFFF, 6);
    commit("cearly");
    chk("r036_err", 32'(err[0]), 32'h1);
    chk("r036_nodone", 32'(done[0]), 32'h0);
    set_chan("pearly", 8'hFF);
    chk("r036_pin0", 32'(po[0]), 32'h0);
    for (int i = 0; i < 3; i++) cycle("pause", 1'b0, 1'b0, 1'b0, 8'($urandom));
    shift_word("s6b", 32'h3F, 6);
    commit("clate");
    chk("r036_done", 32'(done[0]), 32'h1);

    // Multi-hot pin0 field
    do_reset();
    shift_word("s003", 32'h003, CFG);
    commit("c003");
`ifdef CB_ONEHOT_CHECK_EN
    chk("r037_err", 32'(err[0]), 32'h1);
    chk("r037_valid", 32'(valid[0]), 32'h0);
`else
    set_chan("p003a", 8'h02);
    chk("r037_prio0", 32'(po[0][0]), 32'h0);
    set_chan("p003b", 8'h01);
    chk("r037_prio1", 32'(po[0][0]), 32'h1);
`endif

    // Asynchronous reset mid-shift
    do_reset();
    shift_word("s8", 32'hFF, 8);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("arst");
    chk("r038_cfg_out", 32'(cout[0]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    shift_word("s4", 32'hF, 4);
    commit("cpart");
    chk("r038_nodone", 32'(done[0]), 32'h0);
    shift_word("s12", 32'h842, CFG);
    commit("cfull");
    chk("r038_done", 32'(done[0]), 32'h1);

    // Daisy chain: 24 bits split across both blocks, overshift while LOADED
    do_reset();
    shift_word("s24", 32'h0000_0000, 6);
    shift_word("s24", 32'h0042_1842, 2 * CFG);
    commit("c24");
    chk("r039_act0", 32'(valid[0] & valid[1]), 32'h1);
    for (int i = 0; i < 4; i++) set_chan("p24", 8'($urandom));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rnd", 1'($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom_range(0, 19) == 0),
            8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_config_connection_block

`default_nettype wire
